fir_poly_interp: RTL and testbench



---
 rtl/fir_poly_interp_if.sv | 29 ++
 rtl/fir_poly_interp.sv | 161 ++++++++++++++++
 tb/tb_fir_poly_interp.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_poly_interp_if.sv
// Sample/coefficient/output bundle for the polyphase interpolating FIR.
// The DUT takes the slave side; the driver of samples and taps takes master.
interface fir_poly_interp_if #(
  parameter int INPUT_WIDTH   = 14,
  parameter int TAP_WIDTH     = 16,
  parameter int OUTPUT_WIDTH  = 12,
  parameter int L_LOG2        = 5,
  parameter int BANK_LEN_LOG2 = 3
);
  logic                            clk_2mhz_pos_en;
  logic signed [INPUT_WIDTH-1:0]   din;
  logic                            tap_wr_en;
  logic        [BANK_LEN_LOG2-1:0] tap_bank;
  logic        [L_LOG2-1:0]        tap_phase;
  logic signed [TAP_WIDTH-1:0]     tap_data;
  logic signed [OUTPUT_WIDTH-1:0]  dout;
  logic                            dvalid;
  logic                            dsat;

  modport master (
    output clk_2mhz_pos_en, din, tap_wr_en, tap_bank, tap_phase, tap_data,
    input  dout, dvalid, dsat
  );

  modport slave (
    input  clk_2mhz_pos_en, din, tap_wr_en, tap_bank, tap_phase, tap_data,
    output dout, dvalid, dsat
  );
endinterface

// File: rtl/fir_poly_interp.sv
// Polyphase interpolating FIR: one input per low-rate strobe, L outputs per input,
// three-stage pipeline (coef read + snapshot, products, sum/round/saturate).
//
// state  | meaning
// S_IDLE | no phase being issued, waiting for a sample strobe
// S_RUN  | issuing phase_q this cycle; returns to idle after phase L-1
module fir_poly_interp #(
  parameter int N_TAPS         = 120,
  parameter int L              = 20,
  parameter int L_LOG2         = 5,
  parameter int BANK_LEN       = 6,
  parameter int BANK_LEN_LOG2  = 3,
  parameter int INPUT_WIDTH    = 14,
  parameter int TAP_WIDTH      = 16,
  parameter int INTERNAL_WIDTH = 35,
  parameter int OUT_SHIFT      = 15,
  parameter int OUTPUT_WIDTH   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  fir_poly_interp_if.slave   bus
);

  localparam int PROD_W = INPUT_WIDTH + TAP_WIDTH;
  localparam int Q_W    = INTERNAL_WIDTH - OUT_SHIFT;
  localparam int R_W    = Q_W + 1;

  localparam logic [L_LOG2-1:0]        PHASE_LAST = L_LOG2'(L - 1);
  localparam logic [BANK_LEN_LOG2-1:0] BANK_LAST  = BANK_LEN_LOG2'(BANK_LEN - 1);
  localparam logic [OUT_SHIFT-1:0]     HALF       = {1'b1, {(OUT_SHIFT-1){1'b0}}};
  localparam logic signed [R_W-1:0]    SAT_MAX    = R_W'((1 << (OUTPUT_WIDTH-1)) - 1);
  localparam logic signed [R_W-1:0]    SAT_MIN    = R_W'(-(1 << (OUTPUT_WIDTH-1)));

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                          state_q, state_d;
  logic        [L_LOG2-1:0]        phase_q, phase_d;
  logic                            issue;
  logic                            tap_addr_ok;

  logic signed [INPUT_WIDTH-1:0]   hist_q   [BANK_LEN];
  logic signed [TAP_WIDTH-1:0]     coef_mem [BANK_LEN][L];

  logic                            v1_q;
  logic signed [INPUT_WIDTH-1:0]   snap_q   [BANK_LEN];
  logic signed [TAP_WIDTH-1:0]     coef_q   [BANK_LEN];
  logic                            v2_q;
  logic signed [PROD_W-1:0]        prod_q   [BANK_LEN];

  logic signed [INTERNAL_WIDTH-1:0] acc;
  logic signed [Q_W-1:0]            q_floor;
  logic        [OUT_SHIFT-1:0]      frac;
  logic                             round_up;
  logic signed [R_W-1:0]            q_rnd;
  logic signed [OUTPUT_WIDTH-1:0]   dout_d, dout_q;
  logic                             dsat_d, dsat_q;
  logic                             dvalid_q;

  assign issue       = (state_q == S_RUN);
  assign tap_addr_ok = (bus.tap_bank <= BANK_LAST) && (bus.tap_phase <= PHASE_LAST);

  // A strobe always restarts at phase 0, dropping any phases not yet issued.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (bus.clk_2mhz_pos_en) begin
      state_d = S_RUN;
      phase_d = '0;
    end else if (state_q == S_RUN) begin
      if (phase_q == PHASE_LAST) begin
        state_d = S_IDLE;
        phase_d = '0;
      end else begin
        phase_d = phase_q + L_LOG2'(1);
      end
    end
  end

  // Coefficient store is not reset; reads in the pipeline see the pre-write value.
  always_ff @(posedge clk) begin
    if (bus.tap_wr_en && tap_addr_ok) begin
      coef_mem[bus.tap_bank][bus.tap_phase] <= bus.tap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      dsat_q   <= 1'b0;
      for (int j = 0; j < BANK_LEN; j++) begin
        hist_q[j] <= '0;
        snap_q[j] <= '0;
        coef_q[j] <= '0;
        prod_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;

      if (bus.clk_2mhz_pos_en) begin
        hist_q[0] <= bus.din;
        for (int j = 1; j < BANK_LEN; j++) begin
          hist_q[j] <= hist_q[j-1];
        end
      end

      v1_q <= issue;
      if (issue) begin
        for (int j = 0; j < BANK_LEN; j++) begin
          snap_q[j] <= hist_q[j];
          coef_q[j] <= coef_mem[j][phase_q];
        end
      end

      v2_q <= v1_q;
      if (v1_q) begin
        for (int j = 0; j < BANK_LEN; j++) begin
          prod_q[j] <= PROD_W'(snap_q[j]) * PROD_W'(coef_q[j]);
        end
      end

      dvalid_q <= v2_q;
      if (v2_q) begin
        dout_q <= dout_d;
        dsat_q <= dsat_d;
      end
    end
  end

  // Round half to even: bump the floored quotient only above half, or at exactly
  // half when the floored value is odd.
  always_comb begin
    acc = '0;
    for (int j = 0; j < BANK_LEN; j++) begin
      acc = acc + INTERNAL_WIDTH'(prod_q[j]);
    end
    q_floor  = acc[INTERNAL_WIDTH-1:OUT_SHIFT];
    frac     = acc[OUT_SHIFT-1:0];
    round_up = (frac > HALF) || ((frac == HALF) && q_floor[0]);
    q_rnd    = R_W'(q_floor) + R_W'(round_up);
    dout_d   = q_rnd[OUTPUT_WIDTH-1:0];
    dsat_d   = 1'b0;
    if (q_rnd > SAT_MAX) begin
      dout_d = SAT_MAX[OUTPUT_WIDTH-1:0];
      dsat_d = 1'b1;
    end else if (q_rnd < SAT_MIN) begin
      dout_d = SAT_MIN[OUTPUT_WIDTH-1:0];
      dsat_d = 1'b1;
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.dsat   = dsat_q;

endmodule

// File: tb/tb_fir_poly_interp.sv
// Directed bench for fir_poly_interp: hand-computed outputs for gain, bank
// ordering, rounding, saturation, strobe timing, reset and live tap writes.
module tb_fir_poly_interp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_poly_interp_if bus();

  fir_poly_interp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input int d);
    bus.clk_2mhz_pos_en = 1'b1;
    bus.din = 14'(d);
    tick();
    bus.clk_2mhz_pos_en = 1'b0;
  endtask

  task automatic wr_tap(input int b, input int p, input int v);
    bus.tap_wr_en = 1'b1;
    bus.tap_bank  = 3'(b);
    bus.tap_phase = 5'(p);
    bus.tap_data  = 16'(v);
    tick();
    bus.tap_wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_v;
    int cyc;
    int k;
    int rin [4];
    int rexp [4];
    rin  = '{3, 5, -3, 7};
    rexp = '{2, 2, -2, 4};

    bus.clk_2mhz_pos_en = 1'b0;
    bus.din       = '0;
    bus.tap_wr_en = 1'b0;
    bus.tap_bank  = '0;
    bus.tap_phase = '0;
    bus.tap_data  = '0;

    // Reset state
    wait_n(2);
    chk("rst_dout", bus.dout, 0);
    chk("rst_dvalid", bus.dvalid, 0);
    chk("rst_dsat", bus.dsat, 0);
    rst_n = 1'b1;
    wait_n(2);

    // Bank j = 4096*(j+1): impulse of 2048 walks through the banks
    for (int j = 0; j < 6; j++)
      for (int p = 0; p < 20; p++)
        wr_tap(j, p, 4096 * (j + 1));
    for (int c = 0; c < 140; c++) begin
      bus.clk_2mhz_pos_en = (c % 20 == 0);
      bus.din = (c == 0) ? 14'sd2048 : 14'sd0;
      tick();
      cyc = c + 1;
      if (cyc >= 4) begin
        exp_v = ((cyc - 4) < 120) ? 256 * ((cyc - 4) / 20 + 1) : 0;
        chk("s2_dvalid", bus.dvalid, 1);
        chk("s2_dout", bus.dout, exp_v);
      end else begin
        chk("s2_lat_dvalid", bus.dvalid, 0);
      end
    end
    bus.clk_2mhz_pos_en = 1'b0;
    wait_n(25);

    // Bank0 = 16384 (gain 1/2), other banks zero
    for (int j = 0; j < 6; j++)
      for (int p = 0; p < 20; p++)
        wr_tap(j, p, (j == 0) ? 16384 : 0);
    for (int c = 0; c < 80; c++) begin
      bus.clk_2mhz_pos_en = (c % 20 == 0);
      bus.din = 14'sd1000;
      tick();
      cyc = c + 1;
      if (cyc < 4) begin
        chk("s1_lat_dvalid", bus.dvalid, 0);
      end else begin
        chk("s1_dvalid", bus.dvalid, 1);
        chk("s1_dout", bus.dout, 500);
        chk("s1_dsat", bus.dsat, 0);
      end
    end
    bus.clk_2mhz_pos_en = 1'b0;
    wait_n(4);
    chk("s1_tail_dvalid", bus.dvalid, 0);
    chk("s1_hold_dout", bus.dout, 500);
    wait_n(20);

    // Convergent rounding of x/2
    for (int i = 0; i < 4; i++) begin
      strobe(rin[i]);
      wait_n(3);
      chk("s3_round", bus.dout, rexp[i]);
      chk("s3_dsat", bus.dsat, 0);
      wait_n(16);
    end
    wait_n(25);

    // Strobe every 12 cycles: 12 gap-free outputs per input, last one runs 20
    for (int c = 0; c < 64; c++) begin
      bus.clk_2mhz_pos_en = (c % 12 == 0) && (c <= 36);
      bus.din = 14'(1000 * (c / 12 + 1));
      tick();
      cyc = c + 1;
      if (cyc >= 4 && cyc <= 59) begin
        k = (cyc - 4) / 12;
        if (k > 3) k = 3;
        chk("s5_p12_dvalid", bus.dvalid, 1);
        chk("s5_p12_dout", bus.dout, 500 * (k + 1));
      end else begin
        chk("s5_p12_idle", bus.dvalid, 0);
      end
    end
    bus.clk_2mhz_pos_en = 1'b0;
    wait_n(10);

    // 30-cycle gap: 20 valid, 10 idle with held dout, then next sample
    for (int c = 0; c < 60; c++) begin
      bus.clk_2mhz_pos_en = (c == 0) || (c == 30);
      bus.din = (c < 30) ? 14'sd1000 : 14'sd600;
      tick();
      cyc = c + 1;
      if (cyc >= 4 && cyc <= 23) begin
        chk("s5_gap_dvalid_a", bus.dvalid, 1);
        chk("s5_gap_dout_a", bus.dout, 500);
      end else if (cyc >= 24 && cyc <= 33) begin
        chk("s5_gap_idle", bus.dvalid, 0);
        chk("s5_gap_hold", bus.dout, 500);
      end else if (cyc >= 34 && cyc <= 53) begin
        chk("s5_gap_dvalid_b", bus.dvalid, 1);
        chk("s5_gap_dout_b", bus.dout, 300);
      end
    end
    bus.clk_2mhz_pos_en = 1'b0;
    wait_n(15);

    // Reset during phase 7, then recovery with retained taps
    strobe(1000);
    wait_n(7);
    chk("s6_pre_dout", bus.dout, 500);
    chk("s6_pre_dvalid", bus.dvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_dvalid", bus.dvalid, 0);
    chk("s6_rst_dout", bus.dout, 0);
    chk("s6_rst_dsat", bus.dsat, 0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(5);
    chk("s6_idle_dvalid", bus.dvalid, 0);
    strobe(1000);
    wait_n(2);
    chk("s6_lat_dvalid", bus.dvalid, 0);
    wait_n(1);
    chk("s6_post_dvalid", bus.dvalid, 1);
    chk("s6_post_dout", bus.dout, 500);
    wait_n(25);

    // Saturation with bank0 = 32767
    for (int p = 0; p < 20; p++) wr_tap(0, p, 32767);
    strobe(8191);
    wait_n(3);
    chk("s4_pos_dout", bus.dout, 2047);
    chk("s4_pos_dsat", bus.dsat, 1);
    wait_n(16);
    strobe(-8192);
    wait_n(3);
    chk("s4_neg_dout", bus.dout, -2048);
    chk("s4_neg_dsat", bus.dsat, 1);
    wait_n(16);
    strobe(100);
    wait_n(3);
    chk("s4_nosat_dout", bus.dout, 100);
    chk("s4_nosat_dsat", bus.dsat, 0);
    wait_n(25);

    // Per-phase taps 1024*(p+1) with din=32 -> output p+1; phase 10 rewritten
    // in the same cycle it is read, so the new tap shows only next sample
    for (int p = 0; p < 20; p++) wr_tap(0, p, 1024 * (p + 1));
    strobe(32);
    for (int q = 1; q <= 22; q++) begin
      if (q == 11) begin
        bus.tap_wr_en = 1'b1;
        bus.tap_bank  = 3'd0;
        bus.tap_phase = 5'd10;
        bus.tap_data  = 16'sd16384;
      end
      tick();
      bus.tap_wr_en = 1'b0;
      cyc = q + 1;
      if (cyc >= 4) begin
        chk("ramp_dvalid", bus.dvalid, 1);
        chk("ramp_dout", bus.dout, cyc - 3);
      end
    end
    strobe(32);
    wait_n(12);
    chk("wr_ph9", bus.dout, 10);
    tick();
    chk("wr_ph10_new", bus.dout, 16);
    tick();
    chk("wr_ph11", bus.dout, 12);
    wait_n(15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
